// File: rtl/stage_seq.sv
// stage_seq: multicycle sequencer walking one instruction through IFU/IDU/EXU/LSU/WBU
// with retire/cycle counters, GPR write gating and halt/timeout handling.
module stage_seq #(
    parameter int CNT_WIDTH = 32,
    parameter int TMO_WIDTH = 8,
    parameter int TMO_LIMIT = 200
) (
    input  logic                 i_sys_clk,
    input  logic                 i_sys_rst,
    input  logic                 i_sys_en,
    output logic                 o_ifu_ready,
    input  logic                 i_ifu_valid,
    output logic                 o_idu_ready,
    input  logic                 i_idu_valid,
    input  logic                 i_idu_ctr_mem_en,
    input  logic                 i_idu_ctr_halt,
    output logic                 o_exu_ready,
    input  logic                 i_exu_valid,
    output logic                 o_lsu_ready,
    input  logic                 i_lsu_valid,
    output logic                 o_wbu_ready,
    input  logic                 i_wbu_valid,
    output logic                 o_gpr_wr_gate,
    output logic [2:0]           o_state,
    output logic [CNT_WIDTH-1:0] o_cycle_cnt,
    output logic [CNT_WIDTH-1:0] o_retire_cnt,
    output logic                 o_halt,
    output logic                 o_err
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, IF = 3'd1, ID = 3'd2, EX = 3'd3, LS = 3'd4, WB = 3'd5, HALT = 3'd6
    } state_t;

    state_t               state, state_n;
    logic [TMO_WIDTH-1:0] tmo;
    logic                 mem_q, halt_q, hs, active, tmo_hit;

    assign o_ifu_ready   = state == IF;
    assign o_idu_ready   = state == ID;
    assign o_exu_ready   = state == EX;
    assign o_lsu_ready   = state == LS;
    assign o_wbu_ready   = state == WB;
    assign o_gpr_wr_gate = (state == WB) & i_wbu_valid;
    assign o_state       = state;

    always_comb begin
        hs = (o_ifu_ready & i_ifu_valid) | (o_idu_ready & i_idu_valid) | (o_exu_ready & i_exu_valid)
           | (o_lsu_ready & i_lsu_valid) | (o_wbu_ready & i_wbu_valid);
        active = (state >= IF) && (state <= WB);
        tmo_hit = active & ~hs & (tmo == TMO_WIDTH'(TMO_LIMIT - 1));
        state_n = state;
        case (state)
            IDLE:    state_n = i_sys_en ? IF : IDLE;
            IF:      state_n = hs ? ID : IF;
            ID:      state_n = hs ? EX : ID;
            EX:      state_n = hs ? (mem_q ? LS : WB) : EX;
            LS:      state_n = hs ? WB : LS;
            WB:      state_n = hs ? (halt_q ? HALT : IF) : WB;
            HALT:    state_n = HALT;
            default: state_n = IDLE;
        endcase
        if (tmo_hit)
            state_n = HALT;
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            state        <= IDLE;
            tmo          <= '0;
            mem_q        <= 1'b0;
            halt_q       <= 1'b0;
            o_cycle_cnt  <= '0;
            o_retire_cnt <= '0;
            o_halt       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            state <= state_n;
            // every handshake changes state, so a state change is the only clear condition
            tmo <= (state_n != state) ? '0 : (active ? tmo + 1'b1 : tmo);
            if (o_idu_ready & i_idu_valid) begin
                mem_q  <= i_idu_ctr_mem_en;
                halt_q <= i_idu_ctr_halt;
            end
            o_cycle_cnt  <= o_cycle_cnt + {{(CNT_WIDTH-1){1'b0}}, active};
            o_retire_cnt <= o_retire_cnt + {{(CNT_WIDTH-1){1'b0}}, o_wbu_ready & i_wbu_valid};
            o_halt       <= o_halt | (state_n == HALT);
            o_err        <= o_err | tmo_hit;
        end
    end
endmodule

// File: tb/tb_stage_seq.sv
// tb_stage_seq: scoreboard bench for stage_seq with latency-programmable stage responders.
module tb_stage_seq;
    logic        clk = 0, rst = 1, en = 0;
    logic        ifu_r, idu_r, exu_r, lsu_r, wbu_r;
    logic        ifu_v, idu_v, exu_v, lsu_v, wbu_v;
    logic        mem_en = 0, halt_in = 0, gate, halt, err;
    logic [2:0]  state;
    logic [31:0] cyc, ret;
    logic [7:0]  wcnt;
    int          lat[5];
    int          tests = 0, fails = 0, gate_cnt = 0, ls_cyc = 0, ex_cyc = 0;
    logic [2:0]  prev = 0;
    logic [2:0]  exp_q[$];

    stage_seq #(.CNT_WIDTH(32), .TMO_WIDTH(8), .TMO_LIMIT(4)) dut (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_sys_en(en),
        .o_ifu_ready(ifu_r), .i_ifu_valid(ifu_v),
        .o_idu_ready(idu_r), .i_idu_valid(idu_v),
        .i_idu_ctr_mem_en(mem_en), .i_idu_ctr_halt(halt_in),
        .o_exu_ready(exu_r), .i_exu_valid(exu_v),
        .o_lsu_ready(lsu_r), .i_lsu_valid(lsu_v),
        .o_wbu_ready(wbu_r), .i_wbu_valid(wbu_v),
        .o_gpr_wr_gate(gate), .o_state(state),
        .o_cycle_cnt(cyc), .o_retire_cnt(ret),
        .o_halt(halt), .o_err(err)
    );

    always #5 clk = ~clk;

    // each stage answers once it has seen ready for lat[] extra cycles
    always_comb begin
        ifu_v = ifu_r && (int'(wcnt) >= lat[0]);
        idu_v = idu_r && (int'(wcnt) >= lat[1]);
        exu_v = exu_r && (int'(wcnt) >= lat[2]);
        lsu_v = lsu_r && (int'(wcnt) >= lat[3]);
        wbu_v = wbu_r && (int'(wcnt) >= lat[4]);
    end

    always @(posedge clk or posedge rst)
        if (rst)
            wcnt <= 0;
        else if ((ifu_r & ifu_v) | (idu_r & idu_v) | (exu_r & exu_v) | (lsu_r & lsu_v) | (wbu_r & wbu_v))
            wcnt <= 0;
        else if (ifu_r | idu_r | exu_r | lsu_r | wbu_r)
            wcnt <= wcnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic step();
        logic [2:0] e;
        logic [4:0] oh;
        @(negedge clk);
        oh = 5'b0;
        if (state >= 3'd1 && state <= 3'd5)
            oh[state - 3'd1] = 1'b1;
        check("ready_onehot", {27'b0, wbu_r, lsu_r, exu_r, idu_r, ifu_r}, {27'b0, oh});
        if (gate) gate_cnt++;
        if (state == 3'd4) ls_cyc++;
        if (state == 3'd3) ex_cyc++;
        if (state != prev) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'd7;
            check("state_seq", {29'b0, state}, {29'b0, e});
            prev = state;
        end
    endtask

    task automatic run_until_empty();
        int n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            step();
            n++;
        end
        check("seq_done", exp_q.size(), 0);
    endtask

    task automatic push(input logic [2:0] s);
        exp_q.push_back(s);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        #1;
        check("rst_state", {29'b0, state}, 0);
        check("rst_cnt", cyc | ret, 0);
        check("rst_flags", {30'b0, halt, err}, 0);
        @(negedge clk);
        rst = 0;
        prev = 0;
        exp_q.delete();
    endtask

    initial begin
        lat = '{0, 0, 0, 0, 0};
        repeat (2) @(negedge clk);
        check("rst_state", {29'b0, state}, 0);
        check("rst_outs", {24'b0, ifu_r, idu_r, exu_r, lsu_r, wbu_r, gate, halt, err}, 0);
        check("rst_cnt", cyc | ret, 0);
        rst = 0;
        step();
        check("idle_no_en", {29'b0, state}, 0);

        // ALU instruction
        push(1); push(2); push(3); push(5); push(1);
        en = 1;
        step();
        check("if_entry", {29'b0, state}, 1);
        check("if_ready", {31'b0, ifu_r}, 1);
        gate_cnt = 0;
        run_until_empty();
        check("alu_gate", gate_cnt, 1);
        check("alu_retire", ret, 1);
        check("alu_cycles", cyc, 4);

        // load with LSU answering on its 4th cycle (timeout boundary, handshake wins)
        mem_en = 1; lat[3] = 3; ls_cyc = 0;
        push(2); push(3); push(4); push(5); push(1);
        run_until_empty();
        check("ld_ls_cycles", ls_cyc, 4);
        check("ld_retire", ret, 2);
        check("ld_cycles", cyc, 12);
        check("ld_err", {31'b0, err}, 0);

        // halting instruction
        mem_en = 0; halt_in = 1;
        push(2); push(3); push(5); push(6);
        run_until_empty();
        check("hlt_halt", {30'b0, halt, err}, 2);
        check("hlt_retire", ret, 3);
        en = 0; step(); en = 1; step(); step();
        check("hlt_sticky", {29'b0, state}, 6);
        check("hlt_cycles", cyc, 16);

        // EXU never answers -> timeout halt
        do_reset();
        halt_in = 0; lat[2] = 255; ex_cyc = 0;
        push(1); push(2); push(3); push(6);
        run_until_empty();
        check("tmo_ex_cycles", ex_cyc, 4);
        check("tmo_flags", {30'b0, halt, err}, 3);
        check("tmo_retire", ret, 0);
        check("tmo_cycles", cyc, 6);

        // EXU answers on the last allowed cycle
        do_reset();
        lat[2] = 3; ex_cyc = 0;
        push(1); push(2); push(3); push(5); push(1);
        run_until_empty();
        check("edge_ex_cycles", ex_cyc, 4);
        check("edge_err", {30'b0, halt, err}, 0);
        check("edge_retire", ret, 1);

        // asynchronous reset in the middle of LS
        mem_en = 1; lat[3] = 2;
        push(2); push(3); push(4);
        run_until_empty();
        rst = 1;
        #1;
        check("arst_state", {29'b0, state}, 0);
        check("arst_lsu", {31'b0, lsu_r}, 0);
        check("arst_cnt", cyc | ret, 0);
        @(negedge clk);
        rst = 0;
        prev = 0;
        en = 0;
        step();
        check("arst_idle", {29'b0, state}, 0);
        check("arst_retire", ret, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/stage_seq.md
Name: stage_seq

Overview:
- Multicycle instruction sequencer for the l1 core. It drives the IFU, IDU, EXU, LSU and WBU one at a time.
- Each stage gets a ready strobe and answers with a valid. The sequencer walks one instruction through the stages before fetching the next.
- It gates the WBU register-file write, counts cycles and retired instructions, and halts on an ebreak-style halt or a stage timeout.
- It sits at the top of the stage hierarchy, between the system enable and the per-stage i_sys_ready / o_sys_valid pins.

Parameters:
- CNT_WIDTH, 32, width of the cycle and retire counters.
- TMO_WIDTH, 8, width of the per-state timeout counter.
- TMO_LIMIT, 200, cycles a state may wait for its stage valid before an error halt. Must be ≥ 2 and < 2^TMO_WIDTH.

Ports:
- i_sys_clk  in  1  clock, rising edge.
- i_sys_rst  in  1  asynchronous active-high reset.
- i_sys_en  in  1  run enable, sampled in IDLE only.
- o_ifu_ready  out  1  IFU may fetch.
- i_ifu_valid  in  1  IFU done.
- o_idu_ready  out  1  IDU may decode.
- i_idu_valid  in  1  IDU done.
- i_idu_ctr_mem_en  in  1  decoded instr is load/store. Sampled with i_idu_valid.
- i_idu_ctr_halt  in  1  decoded instr is halt. Sampled with i_idu_valid.
- o_exu_ready  out  1  EXU may execute.
- i_exu_valid  in  1  EXU done.
- o_lsu_ready  out  1  LSU may access memory.
- i_lsu_valid  in  1  LSU done.
- o_wbu_ready  out  1  WBU may write back.
- i_wbu_valid  in  1  WBU done.
- o_gpr_wr_gate  out  1  qualifies the WBU GPR write enable.
- o_state  out  3  current state encoding.
- o_cycle_cnt  out  CNT_WIDTH  active cycles.
- o_retire_cnt  out  CNT_WIDTH  retired instructions.
- o_halt  out  1  sequencer halted.
- o_err  out  1  halt was caused by timeout.

Behaviour:
- States and encodings: IDLE=0, IF=1, ID=2, EX=3, LS=4, WB=5, HALT=6. Encoding 7 is illegal and returns to IDLE next cycle.
- Reset is asynchronous and active-high. While i_sys_rst=1:
  - state=IDLE;
  - all ready outputs 0, o_gpr_wr_gate=0;
  - both counters 0, the timeout counter 0;
  - o_halt=0, o_err=0, latched mem_en and halt flags 0.
  - Reset asserted mid-instruction aborts it immediately; no retire is counted.
- Ready outputs are Moore, one-hot from state: IF→o_ifu_ready, ID→o_idu_ready, EX→o_exu_ready, LS→o_lsu_ready, WB→o_wbu_ready. All ready outputs are 0 in IDLE and HALT.
- Handshake: a stage completes in the cycle its ready=1 and its valid=1. The state advances at that clock edge.
  - Minimum residency is 1 cycle per state.
  - A valid from a stage whose ready=0 is ignored.
- Transitions:
  - IDLE→IF when i_sys_en=1.
  - IF→ID.
  - ID→EX; latch i_idu_ctr_mem_en and i_idu_ctr_halt on the handshake.
  - EX→LS if the latched mem_en=1, else EX→WB.
  - LS→WB.
  - WB→HALT if the latched halt=1, else WB→IF.
- Write gate: o_gpr_wr_gate = (state==WB) & i_wbu_valid, combinational. This is the only combinational input-to-output path.
- Retire: o_retire_cnt increments by 1 on each WB handshake, including the halting instruction. It wraps modulo 2^CNT_WIDTH.
- o_cycle_cnt increments in every cycle where state is IF..WB. It holds in IDLE and HALT and wraps modulo 2^CNT_WIDTH.
- Timeout counter:
  - Clears on every state change.
  - Increments each cycle spent in IF..WB without a handshake.
  - If it equals TMO_LIMIT-1 and no handshake occurs that cycle, next state=HALT and o_err is set.
  - A handshake in that same cycle wins: normal transition, no error.
- HALT is terminal. o_halt=1 (registered, asserted the cycle state becomes HALT). It is left only by reset; i_sys_en is ignored.
- o_err stays 0 on a normal halt.
- i_sys_en deassertion outside IDLE has no effect; the instruction runs to completion.

Test Plan:
- Reset with i_sys_en=0: state=0, all outputs 0. Raise i_sys_en → state=1 next cycle, o_ifu_ready=1.
- ALU instr, each stage valid 1 cycle after ready: sequence 1,2,3,5,1. o_gpr_wr_gate pulses once, o_retire_cnt=1, o_cycle_cnt=4 on return to IF.
- Load instr with i_idu_ctr_mem_en=1, LSU valid after 3 cycles of wait: LS state held 4 cycles. Sequence 1,2,3,4,5,1; o_lsu_ready=1 only in LS.
- Halt instr (i_idu_ctr_halt=1): after the WB handshake, state=6, o_halt=1, o_err=0, o_retire_cnt incremented. Toggling i_sys_en leaves state at 6.
- TMO_LIMIT=4, EXU never valid: after 4 cycles in EX, state=6, o_halt=1, o_err=1, retire unchanged. Repeat with i_exu_valid on the 4th cycle → WB, o_err=0.
- i_sys_rst pulsed asynchronously mid-LS: outputs clear before the next clock edge, counters=0, state=IDLE. The dropped instruction is not retired.
